// File: rtl/branch_tracker.sv
// In-order tracker for in-flight branches between fetch/execute and a 2-bit predictor.
// Queues predictions until resolve, drives predictor updates, flushes on mispredict.
module branch_tracker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  output logic                     pred_valid_o,
  output logic                     pred_taken_o,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  output logic                     resolve_ready_o,
  output logic                     mispredict_o,
  output logic                     request_o,
  input  logic                     prediction_i,
  output logic                     result_o,
  output logic                     taken_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [CNT_W-1:0]         total_cnt_o,
  output logic [CNT_W-1:0]         miss_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0]  DepthOcc = OccW'(DEPTH);
  localparam logic [OccW-1:0]  OccOne   = OccW'(1);
  localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  logic            pred_mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            pend_q, pend_d;
  logic            request_q, request_d;
  logic            result_q, result_d;
  logic            taken_q, taken_d;
  logic            pred_valid_q, pred_valid_d;
  logic            pred_taken_q, pred_taken_d;
  logic            mispredict_q, mispredict_d;
  logic [CNT_W-1:0] total_q, total_d, miss_q, miss_d;

  logic res_acc, flush, accept, capture;

  // Pending request counts against capacity so a full queue never overflows on capture.
  assign fetch_ready_o   = !rst_i && ((occ_q + {{PtrW{1'b0}}, pend_q}) < DepthOcc);
  assign resolve_ready_o = !rst_i && (occ_q != '0);

  assign res_acc = resolve_valid_i && resolve_ready_o;
  assign flush   = res_acc && (pred_mem_q[head_q] != resolve_taken_i);
  assign accept  = fetch_valid_i && fetch_ready_o && !flush;
  assign capture = pend_q && !flush;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    pend_d       = accept;
    request_d    = accept;
    result_d     = res_acc;
    taken_d      = taken_q;
    pred_valid_d = capture;
    pred_taken_d = pred_taken_q;
    mispredict_d = flush;
    total_d      = total_q;
    miss_d       = miss_q;

    if (capture) begin
      tail_d       = tail_q + PtrOne;
      occ_d        = occ_d + OccOne;
      pred_taken_d = prediction_i;
    end
    if (res_acc) begin
      head_d  = head_q + PtrOne;
      occ_d   = occ_d - OccOne;
      taken_d = resolve_taken_i;
      if (total_q != CntMax) total_d = total_q + CntOne;
    end
    // Flush drops every younger entry, including one captured this edge.
    if (flush) begin
      head_d = tail_q;
      occ_d  = '0;
      if (miss_q != CntMax) miss_d = miss_q + CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      pend_q       <= 1'b0;
      request_q    <= 1'b0;
      result_q     <= 1'b0;
      taken_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      total_q      <= '0;
      miss_q       <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      pend_q       <= pend_d;
      request_q    <= request_d;
      result_q     <= result_d;
      taken_q      <= taken_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      mispredict_q <= mispredict_d;
      total_q      <= total_d;
      miss_q       <= miss_d;
    end
  end

  // Storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && capture) pred_mem_q[tail_q] <= prediction_i;
  end

  assign request_o    = request_q;
  assign result_o     = result_q;
  assign taken_o      = taken_q;
  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign mispredict_o = mispredict_q;
  assign occupancy_o  = occ_q;
  assign total_cnt_o  = total_q;
  assign miss_cnt_o   = miss_q;

endmodule

// File: tb/tb_branch_tracker.sv
// Bench for branch_tracker: directed vector table plus randomized run against a queue model,
// with a behavioural 2-bit predictor answering on the falling edge.
module tb_branch_tracker;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, fetch_valid = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic prediction = 1'b0;
  logic [1:0] pctr = 2'b00;
  logic fetch_ready, pred_valid, pred_taken, resolve_ready, mispredict, request, result, taken;
  logic [2:0] occupancy;
  logic [15:0] total_cnt, miss_cnt;
  logic s_fetch_ready, s_pred_valid, s_pred_taken, s_resolve_ready, s_mispredict;
  logic s_request, s_result, s_taken;
  logic [2:0] s_occupancy;
  logic [1:0] s_total_cnt, s_miss_cnt;

  branch_tracker #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .resolve_valid_i(resolve_valid),
    .resolve_taken_i(resolve_taken), .resolve_ready_o(resolve_ready),
    .mispredict_o(mispredict), .request_o(request), .prediction_i(prediction),
    .result_o(result), .taken_o(taken), .occupancy_o(occupancy),
    .total_cnt_o(total_cnt), .miss_cnt_o(miss_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation checks.
  branch_tracker #(.DEPTH(DEPTH), .CNT_W(2)) u_small (
    .clk_i(clk), .rst_i(rst), .fetch_valid_i(fetch_valid), .fetch_ready_o(s_fetch_ready),
    .pred_valid_o(s_pred_valid), .pred_taken_o(s_pred_taken), .resolve_valid_i(resolve_valid),
    .resolve_taken_i(resolve_taken), .resolve_ready_o(s_resolve_ready),
    .mispredict_o(s_mispredict), .request_o(s_request), .prediction_i(prediction),
    .result_o(s_result), .taken_o(s_taken), .occupancy_o(s_occupancy),
    .total_cnt_o(s_total_cnt), .miss_cnt_o(s_miss_cnt)
  );

  // Predictor: samples on the falling edge; a same-half-cycle request sees the old counter.
  always @(negedge clk) begin
    if (request === 1'b1) prediction <= pctr[1];
    if (result === 1'b1) begin
      if (taken === 1'b1) pctr <= (pctr == 2'b11) ? 2'b11 : pctr + 2'b01;
      else                pctr <= (pctr == 2'b00) ? 2'b00 : pctr - 2'b01;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: in-flight predictions as a queue, unbounded statistic counts.
  bit mq[$];
  bit m_pend = 0, m_ppred = 0, m_taken = 0, m_rst = 1;
  int m_ctr = 0, m_tot = 0, m_miss = 0;
  bit e_req, e_pv, e_pt, e_res, e_tk, e_mis;

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge(input bit r, input bit fv, input bit rv, input bit rt);
    bit fr, racc, flush, acc, cap;
    m_rst = r;
    if (r) begin
      mq.delete();
      m_pend = 0; m_tot = 0; m_miss = 0; m_taken = 0;
      {e_req, e_pv, e_pt, e_res, e_tk, e_mis} = '0;
      return;
    end
    fr    = (mq.size() + m_pend) < DEPTH;
    racc  = rv && (mq.size() != 0);
    flush = racc && (mq[0] != rt);
    acc   = fv && fr && !flush;
    cap   = m_pend && !flush;
    e_req = acc; e_pv = cap; e_pt = m_ppred; e_res = racc; e_mis = flush;
    if (racc) m_taken = rt;
    e_tk = m_taken;
    if (racc) begin void'(mq.pop_front()); m_tot++; end
    if (cap) mq.push_back(m_ppred);
    if (flush) begin mq.delete(); m_miss++; end
    if (acc) m_ppred = (m_ctr >= 2);
    m_pend = acc;
    if (racc) m_ctr = rt ? ((m_ctr == 3) ? 3 : m_ctr + 1) : ((m_ctr == 0) ? 0 : m_ctr - 1);
  endtask

  task automatic check_model();
    bit efr, err;
    efr = !m_rst && ((mq.size() + m_pend) < DEPTH);
    err = !m_rst && (mq.size() != 0);
    chk("request", request, e_req);
    chk("pred_valid", pred_valid, e_pv);
    if (e_pv) chk("pred_taken", pred_taken, e_pt);
    chk("result", result, e_res);
    chk("taken", taken, e_tk);
    chk("mispredict", mispredict, e_mis);
    chk("occupancy", occupancy, mq.size());
    chk("fetch_ready", fetch_ready, efr);
    chk("resolve_ready", resolve_ready, err);
    chk("total_cnt", total_cnt, sat(m_tot, 16));
    chk("miss_cnt", miss_cnt, sat(m_miss, 16));
    chk("small.total_cnt", s_total_cnt, sat(m_tot, 2));
    chk("small.miss_cnt", s_miss_cnt, sat(m_miss, 2));
    chk("small.outputs",
        {s_request, s_pred_valid, s_pred_taken & e_pv, s_result, s_taken, s_mispredict,
         s_fetch_ready, s_resolve_ready, s_occupancy},
        {e_req, e_pv, e_pt & e_pv, e_res, e_tk, e_mis, efr, err, 3'(mq.size())});
  endtask

  task automatic step(input bit r, input bit fv, input bit rv, input bit rt);
    rst = r; fetch_valid = fv; resolve_valid = rv; resolve_taken = rt;
    model_edge(r, fv, rv, rt);
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  typedef struct {
    bit [3:0] in;   // {rst, fetch_valid, resolve_valid, resolve_taken}
    bit [5:0] o;    // {request, pred_valid, pred_taken, result, taken, mispredict}
    int occ;
    bit fr, rr;
    int tot, miss;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit [3:0] in, input bit [5:0] o, input int occ,
                              input bit fr, input bit rr, input int tot, input int miss);
    vec_t v;
    v.in = in; v.o = o; v.occ = occ; v.fr = fr; v.rr = rr; v.tot = tot; v.miss = miss;
    tbl.push_back(v);
  endfunction

  initial begin
    // Reset, three fetches with predictor at 00, then resolve all not-taken.
    add(4'b1000, 6'b000000, 0, 0, 0, 0, 0);
    add(4'b1000, 6'b000000, 0, 0, 0, 0, 0);
    add(4'b0100, 6'b100000, 0, 1, 0, 0, 0);
    add(4'b0100, 6'b110000, 1, 1, 1, 0, 0);
    add(4'b0100, 6'b110000, 2, 1, 1, 0, 0);
    add(4'b0000, 6'b010000, 3, 1, 1, 0, 0);
    add(4'b0010, 6'b000100, 2, 1, 1, 1, 0);
    add(4'b0010, 6'b000100, 1, 1, 1, 2, 0);
    add(4'b0010, 6'b000100, 0, 1, 0, 3, 0);
    add(4'b0010, 6'b000000, 0, 1, 0, 3, 0);   // resolve on empty queue ignored
    // Fill to DEPTH with a fifth fetch held until one resolve frees an entry.
    add(4'b0100, 6'b100000, 0, 1, 0, 3, 0);
    add(4'b0100, 6'b110000, 1, 1, 1, 3, 0);
    add(4'b0100, 6'b110000, 2, 1, 1, 3, 0);
    add(4'b0100, 6'b110000, 3, 0, 1, 3, 0);
    add(4'b0100, 6'b010000, 4, 0, 1, 3, 0);
    add(4'b0100, 6'b000000, 4, 0, 1, 3, 0);
    add(4'b0110, 6'b000100, 3, 1, 1, 4, 0);
    add(4'b0100, 6'b100000, 3, 0, 1, 4, 0);
    add(4'b0000, 6'b010000, 4, 0, 1, 4, 0);
    add(4'b0010, 6'b000100, 3, 1, 1, 5, 0);
    // Three in flight, oldest resolves taken with a fetch presented: flush, fetch dropped.
    add(4'b0111, 6'b000111, 0, 1, 0, 6, 1);
    add(4'b0000, 6'b000010, 0, 1, 0, 6, 1);
    // Capture and correct resolve on the same edge keep occupancy.
    add(4'b0100, 6'b100010, 0, 1, 0, 6, 1);
    add(4'b0100, 6'b110010, 1, 1, 1, 6, 1);
    add(4'b0010, 6'b010100, 1, 1, 1, 7, 1);
    add(4'b0010, 6'b000100, 0, 1, 0, 8, 1);
    // Four more mispredicts; the CNT_W=2 copy saturates at 3.
    add(4'b0100, 6'b100000, 0, 1, 0, 8, 1);
    add(4'b0000, 6'b010000, 1, 1, 1, 8, 1);
    add(4'b0011, 6'b000111, 0, 1, 0, 9, 2);
    add(4'b0100, 6'b100010, 0, 1, 0, 9, 2);
    add(4'b0000, 6'b010010, 1, 1, 1, 9, 2);
    add(4'b0011, 6'b000111, 0, 1, 0, 10, 3);
    add(4'b0100, 6'b100010, 0, 1, 0, 10, 3);
    add(4'b0000, 6'b011010, 1, 1, 1, 10, 3);
    add(4'b0010, 6'b000101, 0, 1, 0, 11, 4);
    add(4'b0100, 6'b100000, 0, 1, 0, 11, 4);
    add(4'b0000, 6'b010000, 1, 1, 1, 11, 4);
    add(4'b0011, 6'b000111, 0, 1, 0, 12, 5);
    // Reset mid-stream.
    add(4'b0100, 6'b100010, 0, 1, 0, 12, 5);
    add(4'b0100, 6'b111010, 1, 1, 1, 12, 5);
    add(4'b1110, 6'b000000, 0, 0, 0, 0, 0);
    add(4'b0000, 6'b000000, 0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk($sformatf("v%0d.request", i), request, tbl[i].o[5]);
      chk($sformatf("v%0d.pred_valid", i), pred_valid, tbl[i].o[4]);
      if (tbl[i].o[4]) chk($sformatf("v%0d.pred_taken", i), pred_taken, tbl[i].o[3]);
      chk($sformatf("v%0d.result", i), result, tbl[i].o[2]);
      chk($sformatf("v%0d.taken", i), taken, tbl[i].o[1]);
      chk($sformatf("v%0d.mispredict", i), mispredict, tbl[i].o[0]);
      chk($sformatf("v%0d.occupancy", i), occupancy, tbl[i].occ);
      chk($sformatf("v%0d.fetch_ready", i), fetch_ready, tbl[i].fr);
      chk($sformatf("v%0d.resolve_ready", i), resolve_ready, tbl[i].rr);
      chk($sformatf("v%0d.total_cnt", i), total_cnt, tbl[i].tot);
      chk($sformatf("v%0d.miss_cnt", i), miss_cnt, tbl[i].miss);
      chk($sformatf("v%0d.small.miss_cnt", i), s_miss_cnt, sat(tbl[i].miss, 2));
    end

    // Randomized run: alternating fetch-heavy and resolve-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      bit r, fv, rv, rt;
      bit fetch_heavy;
      fetch_heavy = ((i / 150) % 2) == 0;
      r  = ($urandom_range(0, 299) == 0);
      fv = fetch_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rv = fetch_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) rt = mq[0];
      else rt = 1'($urandom_range(0, 1));
      step(r, fv, rv, rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_tracker.md
# branch_tracker

In-order tracker for in-flight branches, sitting between the fetch/execute pipeline and the 2-bit saturating-counter `predictor`. It issues `request` pulses to the predictor and captures the returned `prediction`. It queues each prediction until the branch resolves in execute, then drives the predictor's `result`/`taken` update strobes. On a wrong prediction it flags a mispredict and flushes all younger in-flight branches, and it keeps saturating accuracy statistics.

## Interface
- `DEPTH`, 4: maximum in-flight branches; power of two, ≥2.
- `CNT_W`, 16: width of statistic counters.

- `clk`  in  1  clock; block logic on rising edge (predictor samples on falling edge).
- `rst`  in  1  synchronous, active-high reset.
- `fetch_valid`  in  1  fetch has a branch needing a prediction.
- `fetch_ready`  out  1  tracker can accept a branch this edge.
- `pred_valid`  out  1  one-cycle pulse: `pred_taken` is valid for the oldest unreported fetch.
- `pred_taken`  out  1  prediction returned to fetch.
- `resolve_valid`  in  1  execute resolved the oldest in-flight branch.
- `resolve_taken`  in  1  actual outcome.
- `resolve_ready`  out  1  at least one captured entry is present.
- `mispredict`  out  1  one-cycle pulse: resolved outcome differed; pipeline flush.
- `request`  out  1  to predictor `request`.
- `prediction`  in  1  from predictor `prediction`.
- `result`  out  1  to predictor `result`.
- `taken`  out  1  to predictor `taken`.
- `occupancy`  out  $clog2(DEPTH)+1  captured entries.
- `total_cnt`  out  CNT_W  resolved branches, saturating.
- `miss_cnt`  out  CNT_W  mispredicted branches, saturating.

## Operation
- State:
  - circular queue of DEPTH one-bit predictions with head/tail pointers;
  - `occ` (captured entries);
  - `pend` (1 bit: request issued, prediction not yet captured).
- Fetch accept:
  - Condition: `fetch_valid && fetch_ready && !flush_now`, where `fetch_ready = !rst && (occ + pend) < DEPTH`.
  - Action: `request <= 1`, `pend <= 1`. Otherwise `request <= 0`.
- Capture:
  - On the edge after a `pend` set, if `pend` is set, write `prediction` at tail, increment tail (wraps modulo DEPTH), increment `occ`, clear `pend` unless a new accept sets it again.
  - On that edge, drive `pred_valid <= 1` and `pred_taken <= prediction`.
- Resolve:
  - Accepted when `resolve_valid && resolve_ready`, with `resolve_ready = (occ != 0)`.
  - Action: pop head, `result <= 1`, `taken <= resolve_taken`, `total_cnt` +1 (saturating).
  - Otherwise `result <= 0`. `taken` holds its last value.
  - `resolve_valid` while `resolve_ready` is 0 is ignored; no predictor update, no count.
- Mispredict (`flush_now`): an accepted resolve whose head prediction is not equal to `resolve_taken`.
  - `mispredict <= 1`, `miss_cnt` +1 (saturating).
  - `occ <= 0`, head <= tail, `pend <= 0`.
  - Any fetch presented that edge is dropped (`request <= 0`).
  - A prediction captured that edge is discarded: no `pred_valid`.
- Same-edge capture and correct resolve: both take effect; `occ` unchanged.
- The predictor's update and request in the same half-cycle is permitted. The new prediction uses the pre-update counter; this is defined behaviour.

## Timing
- All outputs are registered except `fetch_ready` and `resolve_ready`, which are combinational from state and `rst`.
- Reset (edge with `rst` = 1):
  - `request`, `result`, `taken`, `pred_valid`, `pred_taken` and `mispredict` are 0.
  - `occ`, `pend`, pointers, `total_cnt` and `miss_cnt` are 0.
  - `fetch_ready` and `resolve_ready` are 0 while `rst` is high.
- Reset mid-operation discards all entries. The predictor counter is not reset by this block.
- Fetch-to-prediction latency:
  - Accept at edge n gives `request` high during cycle n.
  - The predictor samples at the falling edge in cycle n.
  - Capture and `pred_valid` happen at edge n+1.
- Throughput: one fetch per cycle, sustained.
- Resolve at edge n: `result`/`taken` high during cycle n; the predictor updates at that falling edge. `mispredict` is a pulse in cycle n.
- Full: with `occ + pend == DEPTH`, `fetch_ready` is 0. It rises in the cycle after a resolve frees an entry.
- Counters stop at 2^CNT_W−1 and never wrap.

## Test plan
- Reset, then 3 fetches on consecutive edges with the predictor in state 00 → `request` high for 3 cycles; `pred_valid` pulses 3× with `pred_taken` = 0; `occupancy` = 3.
- Resolve those 3 as not-taken → `result` pulses 3×, `taken` = 0, no `mispredict`, `total_cnt` = 3, `miss_cnt` = 0, `occupancy` = 0.
- Fill DEPTH = 4 with a 5th `fetch_valid` held → `fetch_ready` = 0 until one resolve; the 5th branch is accepted on the next edge.
- 3 in flight (predicted 0), oldest resolves taken, with a fetch presented the same edge → `mispredict` pulse, `occupancy` = 0, no `request` for the dropped fetch, `miss_cnt` = 1.
- `resolve_valid` with empty queue → `result` stays 0, counts unchanged; capture and correct resolve on the same edge → `occupancy` unchanged.
- Force `miss_cnt` near saturation (CNT_W = 2) with 4 mispredicts → `miss_cnt` = 3; `rst` mid-stream → all outputs at reset values on the next edge.
